// File: rtl/fn_sw_arb.sv
// Round-robin arbiter/sequencer sharing one 2:1 function switch between two requesters.
// Optional hold limit (max consecutive grant cycles under contention): define FN_SW_ARB_HOLD_LIMIT_EN.
module fn_sw_arb #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             valid
);

    // Grant bits double as the state encoding, so gnt0/gnt1 are mutually exclusive by construction.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_e;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("fn_sw_arb: MAX_HOLD must be in 2..255");
    end

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             valid_q, valid_d;
    logic             hold_hit;

`ifdef FN_SW_ARB_HOLD_LIMIT_EN
    logic [7:0] hold_q, hold_d;
    assign hold_hit = (hold_q == 8'(MAX_HOLD - 1));
`else
    assign hold_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) state_d = last_q ? G0 : G1;
                else if (req0)    state_d = G0;
                else if (req1)    state_d = G1;
            end
            G0: begin
                if (req0) begin
                    if (hold_hit && req1) state_d = G1;
                end else if (req1) begin
                    state_d = G1;
                end else begin
                    state_d = IDLE;
                end
            end
            G1: begin
                if (req1) begin
                    if (hold_hit && req0) state_d = G0;
                end else if (req0) begin
                    state_d = G0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        last_d = last_q;
        if (state_d == G0) last_d = 1'b0;
        if (state_d == G1) last_d = 1'b1;

        // sel and y only move while someone owns the switch; in IDLE they hold.
        sel_d = sel_q;
        if (state_d == G0) sel_d = 1'b0;
        if (state_d == G1) sel_d = 1'b1;

        valid_d = (state_d != IDLE);
        y_d     = valid_d ? (sel_d ? b : a) : y_q;
    end

`ifdef FN_SW_ARB_HOLD_LIMIT_EN
    always_comb begin
        hold_d = hold_q;
        if (state_d == IDLE || state_d != state_q) hold_d = 8'd0;
        else if (!hold_hit)                        hold_d = hold_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) hold_q <= 8'd0;
        else        hold_q <= hold_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign gnt0  = state_q[0];
    assign gnt1  = state_q[1];
    assign sel   = sel_q;
    assign y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_fn_sw_arb.sv
// Vector table + scoreboard bench for fn_sw_arb, with a hand-written hold-limit sequence.
module tb_fn_sw_arb;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n, req0, req1;
    logic [W-1:0] a, b, y;
    logic         gnt0, gnt1, sel, valid;

    fn_sw_arb #(.WIDTH(W), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .a(a), .b(b),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .y(y), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n, r0, r1;
        logic [W-1:0] a, b;
        logic         g0, g1, s;
        logic [W-1:0] y;
        logic         v;
    } vec_t;

    typedef struct {
        logic         g0, g1, s;
        logic [W-1:0] y;
        logic         v;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic rs, input logic r0, input logic r1,
                       input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic g0, input logic g1, input logic s,
                       input logic [W-1:0] yy, input logic v);
        vec_t t;
        t.rst_n = rs; t.r0 = r0; t.r1 = r1; t.a = ai; t.b = bi;
        t.g0 = g0; t.g1 = g1; t.s = s; t.y = yy; t.v = v;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input exp_t e);
        tests++;
        if ({gnt0, gnt1, sel, y, valid} !== {e.g0, e.g1, e.s, e.y, e.v}) begin
            fails++;
            $display("FAIL %s: got g0=%b g1=%b sel=%b y=%0h valid=%b, required g0=%b g1=%b sel=%b y=%0h valid=%b",
                     name, gnt0, gnt1, sel, y, valid, e.g0, e.g1, e.s, e.y, e.v);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    initial begin
        exp_t e;
        int   g0_cycles;
        bit   seen_g1;

        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; a = '0; b = '0;

        //  rst r0 r1 a    b      g0 g1 s  y     v
        // reset, then single request
        add(0, 0, 0, 4'h0, 4'h0,  0, 0, 0, 4'h0, 0);
        add(0, 1, 0, 4'h1, 4'h0,  0, 0, 0, 4'h0, 0);
        add(1, 1, 0, 4'h1, 4'h0,  1, 0, 0, 4'h1, 1);
        add(1, 1, 0, 4'h1, 4'h0,  1, 0, 0, 4'h1, 1);
        add(1, 0, 0, 4'h1, 4'h0,  0, 0, 0, 4'h1, 0);
        // tie after reset -> requester 0, then switch-over with no bubble
        add(0, 0, 0, 4'h0, 4'h0,  0, 0, 0, 4'h0, 0);
        add(1, 1, 1, 4'h2, 4'h1,  1, 0, 0, 4'h2, 1);
        add(1, 0, 1, 4'h2, 4'h1,  0, 1, 1, 4'h1, 1);
        add(1, 0, 0, 4'h2, 4'h1,  0, 0, 1, 4'h1, 0);
        // round-robin bursts: 0,1,0,1
        add(1, 1, 1, 4'h5, 4'hA,  1, 0, 0, 4'h5, 1);
        add(1, 1, 1, 4'h5, 4'hA,  1, 0, 0, 4'h5, 1);
        add(1, 1, 1, 4'h5, 4'hA,  1, 0, 0, 4'h5, 1);
        add(1, 0, 1, 4'h5, 4'hA,  0, 1, 1, 4'hA, 1);
        add(1, 1, 1, 4'h5, 4'hA,  0, 1, 1, 4'hA, 1);
        add(1, 1, 1, 4'h5, 4'hA,  0, 1, 1, 4'hA, 1);
        add(1, 1, 0, 4'h5, 4'hA,  1, 0, 0, 4'h5, 1);
        add(1, 1, 1, 4'h5, 4'hA,  1, 0, 0, 4'h5, 1);
        add(1, 1, 1, 4'h5, 4'hA,  1, 0, 0, 4'h5, 1);
        // req1 alone for 4 cycles, then release: sel/y hold
        add(1, 0, 1, 4'h5, 4'hA,  0, 1, 1, 4'hA, 1);
        add(1, 0, 1, 4'h5, 4'hA,  0, 1, 1, 4'hA, 1);
        add(1, 0, 1, 4'h5, 4'hA,  0, 1, 1, 4'hA, 1);
        add(1, 0, 1, 4'h5, 4'hA,  0, 1, 1, 4'hA, 1);
        add(1, 0, 0, 4'h5, 4'h3,  0, 0, 1, 4'hA, 0);
        // reset mid-grant, then tie goes to requester 0
        add(1, 0, 1, 4'h5, 4'hA,  0, 1, 1, 4'hA, 1);
        add(0, 1, 1, 4'h5, 4'hA,  0, 0, 0, 4'h0, 0);
        add(1, 1, 1, 4'h6, 4'h9,  1, 0, 0, 4'h6, 1);
        add(1, 0, 0, 4'h6, 4'h9,  0, 0, 0, 4'h6, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; req0 = vecs[i].r0; req1 = vecs[i].r1;
            a = vecs[i].a; b = vecs[i].b;
            e.g0 = vecs[i].g0; e.g1 = vecs[i].g1; e.s = vecs[i].s;
            e.y = vecs[i].y; e.v = vecs[i].v;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d", i), e);
        end

        // hold limit: req0 held, req1 joins after the grant
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b0; a = 4'h7; b = 4'h8;
        @(posedge clk); #1;
        chk_bit("hold_first_gnt0", gnt0, 1'b1);
        g0_cycles = gnt0 ? 1 : 0;
        seen_g1   = 1'b0;
        @(negedge clk);
        req1 = 1'b1;
        for (int n = 0; n < 12 && !seen_g1; n++) begin
            @(posedge clk); #1;
            if (gnt1) seen_g1 = 1'b1;
            else if (gnt0) g0_cycles++;
        end
`ifdef FN_SW_ARB_HOLD_LIMIT_EN
        chk_bit("hold_switch_seen", seen_g1, 1'b1);
        tests++;
        if (g0_cycles != 4) begin
            fails++;
            $display("FAIL hold_g0_len: got %0d cycles, required 4", g0_cycles);
        end
        e.g0 = 0; e.g1 = 1; e.s = 1; e.y = 4'h8; e.v = 1;
        check("hold_preempt_out", e);
`else
        chk_bit("nohold_no_switch", seen_g1, 1'b0);
        chk_bit("nohold_gnt0_kept", gnt0, 1'b1);
        @(negedge clk);
        req0 = 1'b0;
        @(posedge clk); #1;
        e.g0 = 0; e.g1 = 1; e.s = 1; e.y = 4'h8; e.v = 1;
        check("nohold_release_out", e);
`endif
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        chk_bit("final_idle_valid", valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
